dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the byte-lane data memory (four 8-bit banks, lanes 0..3) between the pipeline MEM stage and a debug/loader port.
- Sits between the MEM stage and the data memory wrapper.
- Generates per-lane write enables and replicated write data for byte, half and word stores.
- Aligns and extends load data returned by the synchronous-read memory.
- Stalls the pipeline when the debug port holds the grant.

Parameters:
- WORD_ADDR_W, 8, word-address width into the memory banks (depth 2^WORD_ADDR_W words).

Ports:
- CLK  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cpu_req  input  1  MEM-stage access request.
- cpu_we  input  1  1 = store, 0 = load.
- cpu_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- cpu_sext  input  1  load result sign-extended when 1, zero-extended when 0.
- cpu_addr  input  32  byte address.
- cpu_wdata  input  32  store data (LSB-justified).
- cpu_stall  output  1  CPU request not granted this cycle.
- cpu_rvalid  output  1  load data valid.
- cpu_rdata  output  32  aligned, extended load data.
- misalign_err  output  1  one-cycle pulse on a misaligned or illegal CPU access.
- dbg_req  input  1  debug word access request; held until granted.
- dbg_we  input  1  debug store when 1.
- dbg_addr  input  WORD_ADDR_W  debug word address.
- dbg_wdata  input  32  debug store word.
- dbg_gnt  output  1  debug request accepted this cycle.
- dbg_rvalid  output  1  debug load data valid.
- dbg_rdata  output  32  raw debug load word.
- mem_addr  output  WORD_ADDR_W  word address to all banks.
- mem_we  output  4  per-lane write enable (bit n = lane n).
- mem_wdata  output  32  lane data; lane n = bits [8n+7:8n].
- mem_rdata  input  32  bank read word, valid the cycle after the address is presented.

Behaviour:
- Arbitration:
  - Combinational grant each cycle; a single requester always wins.
  - When both request, grant goes to the requester not granted last; state register last_gnt.
  - Reset value of last_gnt = DBG, so the CPU wins the first conflict.
  - last_gnt updates only on a cycle with a grant.
- cpu_stall = cpu_req & ~cpu_grant. The CPU holds all inputs stable while stalled.
- Granted CPU access:
  - mem_addr = cpu_addr[WORD_ADDR_W+1:2].
  - Store, byte: mem_we = 0001 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - Store, half: addr[1]=0 -> mem_we 0011, addr[1]=1 -> mem_we 1100; mem_wdata = {2{wdata[15:0]}}.
  - Store, word: mem_we 1111; mem_wdata = wdata.
- Misalignment:
  - Misaligned cases: half with addr[0]=1, word with addr[1:0]!=00, or size=11.
  - The access is still granted and consumed, but mem_we = 0000 and no rvalid is produced.
  - misalign_err = 1 in the following cycle, for one cycle.
- Granted debug access: mem_addr = dbg_addr; mem_we = 1111 if dbg_we else 0000; mem_wdata = dbg_wdata; dbg_gnt = 1.
- Load latency: exactly 1 cycle. On a granted load, register the requester id, addr[1:0], size and sext.
  - Next cycle, the matching rvalid pulses for one cycle.
  - cpu_rdata = (mem_rdata >> 8*offset), masked to 8/16/32 bits, then extended per sext.
  - dbg_rdata = mem_rdata unmodified.
- Back-to-back grants are allowed every cycle; rvalids are pipelined one cycle behind their grants.
- Idle cycle (no grant): mem_we = 0000; mem_addr and mem_wdata are don't-care.
- Reset:
  - Asynchronous; clears last_gnt (to DBG), cpu_rvalid, dbg_rvalid, misalign_err and the registered load context.
  - cpu_rdata and dbg_rdata reset to 0.
  - While rst = 1: mem_we forced to 0000, dbg_gnt = 0, cpu_stall = cpu_req.
  - A load granted in the cycle reset asserts produces no rvalid.

Test Plan:
- Word 0 preloaded with lanes 0..3 = 12,34,78,56. CPU load, word size, addr 0x0 -> cpu_rvalid next cycle, cpu_rdata = 0x56783412.
- Word 1 = 0x9ABCDEF0. CPU load byte at 0x5 with sext = 1 -> 0xFFFFFFDE. Half at 0x6 with sext = 0 -> 0x00009ABC.
- CPU store byte 0xAB at 0x3 -> mem_we = 1000, mem_wdata = 0xABABABAB. Readback of word 0 = 0xAB783412.
- cpu_req and dbg_req asserted together for 4 cycles, both loads -> grants alternate CPU, DBG, CPU, DBG. cpu_stall high in cycles 2 and 4. Each rvalid is one cycle after its grant.
- CPU word store at 0x6 -> mem_we = 0000, misalign_err pulses the next cycle, memory unchanged, no stall.
- Assert rst in the cycle a debug load is granted -> dbg_rvalid stays 0. After release, the first conflicting request goes to the CPU.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the byte-lane data memory between the MEM stage and a debug port; load data returns 1 cycle after grant.
// Conflicts alternate via last_gnt; the loser is held off (cpu_stall high / dbg_gnt low) until it wins.
module dmem_arbiter #(
    parameter int WORD_ADDR_W = 8
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [1:0]             cpu_size,
    input  logic                   cpu_sext,
    input  logic [31:0]            cpu_addr,
    input  logic [31:0]            cpu_wdata,
    output logic                   cpu_stall,
    output logic                   cpu_rvalid,
    output logic [31:0]            cpu_rdata,
    output logic                   misalign_err,
    input  logic                   dbg_req,
    input  logic                   dbg_we,
    input  logic [WORD_ADDR_W-1:0] dbg_addr,
    input  logic [31:0]            dbg_wdata,
    output logic                   dbg_gnt,
    output logic                   dbg_rvalid,
    output logic [31:0]            dbg_rdata,
    output logic [WORD_ADDR_W-1:0] mem_addr,
    output logic [3:0]             mem_we,
    output logic [31:0]            mem_wdata,
    input  logic [31:0]            mem_rdata
);

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DBG = 1'b1;

    logic        last_gnt;
    logic        cpu_grant;
    logic        dbg_grant;
    logic        cpu_misalign;

    // Registered context of the load issued last cycle
    logic        ld_cpu;
    logic        ld_dbg;
    logic [1:0]  ld_off;
    logic [1:0]  ld_size;
    logic        ld_sext;

    logic [31:0] rd_shifted;
    logic [31:0] rd_ext;

    logic        unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[31:WORD_ADDR_W+2];

    always_comb begin
        case (cpu_size)
            2'b00:   cpu_misalign = 1'b0;
            2'b01:   cpu_misalign = cpu_addr[0];
            2'b10:   cpu_misalign = |cpu_addr[1:0];
            default: cpu_misalign = 1'b1;
        endcase
    end

    // Nothing is granted while reset is held
    always_comb begin
        cpu_grant = 1'b0;
        dbg_grant = 1'b0;
        if (!rst) begin
            if (cpu_req && (!dbg_req || last_gnt == GNT_DBG)) begin
                cpu_grant = 1'b1;
            end else if (dbg_req) begin
                dbg_grant = 1'b1;
            end
        end
    end

    assign cpu_stall = cpu_req & ~cpu_grant;
    assign dbg_gnt   = dbg_grant;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 4'b0000;
        mem_wdata = '0;
        if (cpu_grant) begin
            mem_addr = cpu_addr[WORD_ADDR_W+1:2];
            case (cpu_size)
                2'b00:   mem_wdata = {4{cpu_wdata[7:0]}};
                2'b01:   mem_wdata = {2{cpu_wdata[15:0]}};
                default: mem_wdata = cpu_wdata;
            endcase
            if (cpu_we && !cpu_misalign) begin
                case (cpu_size)
                    2'b00:   mem_we = 4'b0001 << cpu_addr[1:0];
                    2'b01:   mem_we = cpu_addr[1] ? 4'b1100 : 4'b0011;
                    default: mem_we = 4'b1111;
                endcase
            end
        end else if (dbg_grant) begin
            mem_addr  = dbg_addr;
            mem_we    = dbg_we ? 4'b1111 : 4'b0000;
            mem_wdata = dbg_wdata;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            last_gnt     <= GNT_DBG;
            ld_cpu       <= 1'b0;
            ld_dbg       <= 1'b0;
            ld_off       <= 2'b00;
            ld_size      <= 2'b00;
            ld_sext      <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            if (cpu_grant) begin
                last_gnt <= GNT_CPU;
            end else if (dbg_grant) begin
                last_gnt <= GNT_DBG;
            end
            ld_cpu       <= cpu_grant & ~cpu_we & ~cpu_misalign;
            ld_dbg       <= dbg_grant & ~dbg_we;
            misalign_err <= cpu_grant & cpu_misalign;
            if (cpu_grant && !cpu_we) begin
                ld_off  <= cpu_addr[1:0];
                ld_size <= cpu_size;
                ld_sext <= cpu_sext;
            end
        end
    end

    // Align the returned word to the requested byte, then mask and extend
    always_comb begin
        rd_shifted = mem_rdata >> {ld_off, 3'b000};
        case (ld_size)
            2'b00:   rd_ext = {{24{ld_sext & rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01:   rd_ext = {{16{ld_sext & rd_shifted[15]}}, rd_shifted[15:0]};
            default: rd_ext = rd_shifted;
        endcase
    end

    assign cpu_rvalid = ld_cpu;
    assign dbg_rvalid = ld_dbg;
    assign cpu_rdata  = ld_cpu ? rd_ext : 32'h0;
    assign dbg_rdata  = ld_dbg ? mem_rdata : 32'h0;

endmodule
